// File: rtl/uart_rx_buffer.sv
`timescale 1ns/1ps
// uart_rx_buffer: 8N1 UART receiver feeding a first-word fall-through byte FIFO.
// Start-bit glitches are rejected. A stop bit sampled low drops the byte and
// raises a sticky frame error. A byte arriving while the FIFO is full is
// dropped and raises a sticky overrun.
module uart_rx_buffer #(
  parameter int BUS_FREQ        = 100,
  parameter int BAUD            = 115200,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = (BUS_FREQ * 1_000_000) / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OCC_W        = FIFO_DEPTH_LOG2 + 1;

  // The counter counts down to zero, so the load value is one less than the interval.
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
  localparam logic [OCC_W-1:0]           OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]           OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic [1:0]       r_sync;
  logic             w_rx;
  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_push;
  logic             r_ferr_evt;

  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] w_rd_ptr_inc;
  logic [OCC_W-1:0]           r_count;
  logic [7:0]                 r_head;
  logic                       r_overrun;
  logic                       r_frame_err;

  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_ovf_evt;

  // Two-flop synchronizer. It resets to the idle-high line level, so nothing
  // starts on the first clock after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= 2'b11;
    else      r_sync <= {r_sync[0], rx};
  end

  assign w_rx = r_sync[1];

  // Receive FSM. It samples mid-bit and emits one-cycle push and frame-error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_push     <= 1'b0;
      r_ferr_evt <= 1'b0;
    end else begin
      r_push     <= 1'b0;
      r_ferr_evt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx) begin
            r_state    <= START;
            r_bit_cnt  <= '0;
            r_baud_cnt <= HALF_LOAD;
          end
        end
        START: begin
          if (r_baud_cnt == '0) begin
            if (!w_rx) begin
              r_state    <= DATA;
              r_baud_cnt <= FULL_LOAD;
            end else begin
              // The line went high again before mid start bit: treat it as noise.
              r_state <= IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end
        DATA: begin
          if (r_baud_cnt == '0) begin
            r_shift    <= {w_rx, r_shift[7:1]};
            r_baud_cnt <= FULL_LOAD;
            if (r_bit_cnt == 3'd7) r_state <= STOP;
            else                   r_bit_cnt <= r_bit_cnt + 3'd1;
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end
        STOP: begin
          if (r_baud_cnt == '0) begin
            if (w_rx) begin
              r_push  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_ferr_evt <= 1'b1;
              r_state    <= WAIT_IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - BAUD_ONE;
          end
        end
        WAIT_IDLE: begin
          // Stay here for a held-low line (break) so it yields only one frame error.
          if (w_rx) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_full       = (r_count == OCC_FULL);
  assign w_pop        = rd_en && (r_count != '0);
  assign w_wr         = r_push && (!w_full || w_pop);
  assign w_ovf_evt    = r_push && w_full && !w_pop;
  assign w_rd_ptr_inc = r_rd_ptr + PTR_ONE;

  // FIFO storage. It has no reset and only the write port is clocked.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  // Pointers and occupancy. The pointers wrap naturally at the FIFO depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= w_rd_ptr_inc;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered head byte for fall-through reads. It holds its last value when the FIFO empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= 8'h00;
    end else if (w_pop) begin
      if (r_count > OCC_ONE) r_head <= r_mem[w_rd_ptr_inc];
      else if (w_wr)         r_head <= r_shift;
    end else if (w_wr && (r_count == '0)) begin
      r_head <= r_shift;
    end
  end

  // Sticky error flags. A new error event takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovf_evt)    r_overrun <= 1'b1;
      else if (clr_err) r_overrun <= 1'b0;
      if (r_ferr_evt)   r_frame_err <= 1'b1;
      else if (clr_err) r_frame_err <= 1'b0;
    end
  end

  assign rx_data   = r_head;
  assign rx_valid  = (r_count != '0);
  assign rx_full   = w_full;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_buffer.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_buffer at 10 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_buffer;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  uart_rx_buffer #(
    .BUS_FREQ(100),
    .BAUD(10_000_000),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rd_en(rd_en),
    .clr_err(clr_err),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_full(rx_full),
    .overrun(overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end else begin
      $display("ok   %s = %b", name, act);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s = %02h", name, act);
    end
  endtask

  // Advance n rising edges, then step 1 ns past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  // Drive one frame starting 1 ns after a rising edge; rx is left at the stop level.
  // mode 1: check that rx_valid rises exactly on the clock after the stop sample.
  // mode 2: hold rd_en in the push cycle.
  task automatic send(input logic [7:0] b, input logic stop, input int mode);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(8);
    if (mode == 1) check1("valid_before_push", rx_valid, 1'b0);
    if (mode == 2) rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    if (mode == 1) check1("valid_after_push", rx_valid, 1'b1);
    tick(1);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h7E, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};

    // Reset state.
    tick(3);
    check1("rst_valid", rx_valid, 1'b0);
    check1("rst_full", rx_full, 1'b0);
    check1("rst_overrun", overrun, 1'b0);
    check1("rst_frame_err", frame_err, 1'b0);
    check8("rst_data", rx_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    tick(2);

    // A pop while empty has no effect.
    pop();
    check1("empty_pop_valid", rx_valid, 1'b0);
    check1("empty_pop_overrun", overrun, 1'b0);

    // Receive 0x55, check push latency, then read it out.
    send(8'h55, 1'b1, 1);
    check8("byte55_data", rx_data, 8'h55);
    pop();
    check1("byte55_popped", rx_valid, 1'b0);

    // Table of frames with good and bad stop bits.
    foreach (vecs[k]) begin
      send(vecs[k].data, vecs[k].stop, 0);
      rx = 1'b1;
      tick(2 * CPB);
      check1($sformatf("vec%0d_valid", k), rx_valid, vecs[k].exp_valid);
      if (vecs[k].exp_valid) check8($sformatf("vec%0d_data", k), rx_data, vecs[k].exp_data);
      check1($sformatf("vec%0d_frame_err", k), frame_err, vecs[k].exp_ferr);
      check1($sformatf("vec%0d_overrun", k), overrun, 1'b0);
      if (rx_valid) pop();
      if (vecs[k].exp_ferr) begin
        clear_errors();
        check1($sformatf("vec%0d_ferr_cleared", k), frame_err, 1'b0);
      end
    end

    // A 3-clock low glitch is rejected.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2 * CPB);
    check1("glitch_valid", rx_valid, 1'b0);
    check1("glitch_frame_err", frame_err, 1'b0);
    check1("glitch_overrun", overrun, 1'b0);

    // Bad stop bit followed by a 50-clock break gives one frame error.
    send(8'hA3, 1'b0, 0);
    check1("break_frame_err", frame_err, 1'b1);
    tick(5);
    clear_errors();
    tick(44);
    check1("break_single_event", frame_err, 1'b0);
    check1("break_fifo_empty", rx_valid, 1'b0);
    rx = 1'b1;
    tick(2 * CPB);
    check1("break_end_no_event", frame_err, 1'b0);
    send(8'h0F, 1'b1, 0);
    tick(2);
    check1("after_break_valid", rx_valid, 1'b1);
    check8("after_break_data", rx_data, 8'h0F);
    pop();

    // Five bytes with no reads: full after 4, overrun after 5.
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1, 0);
      check1($sformatf("fill%0d_full", i), rx_full, (i >= 4));
      check1($sformatf("fill%0d_overrun", i), overrun, (i >= 5));
    end
    for (int i = 1; i <= 4; i++) begin
      check8($sformatf("drain%0d_data", i), rx_data, 8'(i));
      pop();
    end
    check1("drain_empty", rx_valid, 1'b0);
    clear_errors();
    check1("overrun_cleared", overrun, 1'b0);

    // Full FIFO with a pop coinciding with the push of 0x99.
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b1, 0);
    send(8'h33, 1'b1, 0);
    send(8'h44, 1'b1, 0);
    check1("refill_full", rx_full, 1'b1);
    send(8'h99, 1'b1, 2);
    check1("pushpop_overrun", overrun, 1'b0);
    check1("pushpop_full", rx_full, 1'b1);
    check8("pushpop_rd0", rx_data, 8'h22);
    pop();
    check8("pushpop_rd1", rx_data, 8'h33);
    pop();
    check8("pushpop_rd2", rx_data, 8'h44);
    pop();
    check8("pushpop_rd3", rx_data, 8'h99);
    pop();
    check1("pushpop_empty", rx_valid, 1'b0);

    // Reset during bit 4 of a frame, with one byte already buffered.
    send(8'h5A, 1'b1, 0);
    check1("prerst_valid", rx_valid, 1'b1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC3 >> i) & 8'h01;
      tick(CPB);
    end
    rx = 1'b0;
    tick(5);
    rst = 1'b0;
    #1;
    check1("midrst_valid", rx_valid, 1'b0);
    check8("midrst_data", rx_data, 8'h00);
    check1("midrst_full", rx_full, 1'b0);
    check1("midrst_frame_err", frame_err, 1'b0);
    rx = 1'b1;
    tick(3);
    @(negedge clk);
    rst = 1'b1;
    tick(2 * CPB);
    check1("postrst_valid", rx_valid, 1'b0);
    check1("postrst_frame_err", frame_err, 1'b0);
    send(8'hC3, 1'b1, 0);
    tick(2);
    check1("postrst_rx_valid", rx_valid, 1'b1);
    check8("postrst_rx_data", rx_data, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter BUS_FREQ, default 100, clock frequency in MHz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter FIFO_DEPTH_LOG2, default 3, receive FIFO holds 2**FIFO_DEPTH_LOG2 bytes.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; asynchronous assertion, active-low.
REQ-006 rx  input  1  serial line, idle high; consumes the SoC uart_tx output.
REQ-007 rd_en  input  1  pop request for the FIFO head.
REQ-008 clr_err  input  1  clears sticky error flags.
REQ-009 rx_data  output  8  FIFO head byte, first-word fall-through.
REQ-010 rx_valid  output  1  FIFO non-empty.
REQ-011 rx_full  output  1  FIFO full.
REQ-012 overrun  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-013 frame_err  output  1  sticky; a stop bit was sampled low.

Function
REQ-014 Local CLKS_PER_BIT SHALL be (BUS_FREQ*1_000_000)/BAUD, truncated; HALF_BIT SHALL be CLKS_PER_BIT/2, truncated.
REQ-015 rx SHALL pass through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE: synchronized rx = 0 -> START, bit counter cleared, baud counter loaded.
REQ-018 START: after HALF_BIT clocks, sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no flag set).
REQ-019 DATA: sample every CLKS_PER_BIT clocks; 8 bits, LSB first, shifted into a byte register; after the 8th bit -> STOP.
REQ-020 STOP: sample after CLKS_PER_BIT clocks; 1 -> push byte, go IDLE on the next clock; 0 -> drop byte, set frame_err, go WAIT_IDLE.
REQ-021 WAIT_IDLE: stay until synchronized rx = 1, then IDLE; a line held low (break) SHALL produce exactly one frame_err event.
REQ-022 A pushed byte SHALL appear on rx_data with rx_valid = 1 on the clock after the stop-bit sample.
REQ-023 Push when full and no simultaneous pop: byte dropped, overrun set, FIFO contents unchanged.
REQ-024 Push and pop in the same cycle while full: pop applies first, push accepted, overrun not set.
REQ-025 Push and pop in the same cycle while non-empty and not full: occupancy unchanged, order preserved.
REQ-026 rd_en while empty SHALL be ignored: no pointer move, no flag change.
REQ-027 Read and write pointers SHALL wrap modulo 2**FIFO_DEPTH_LOG2; occupancy counter width FIFO_DEPTH_LOG2+1.
REQ-028 clr_err SHALL clear overrun and frame_err; if a set event coincides with clr_err, set wins.
REQ-029 rx_data SHALL be held at the last head value when empty; its value is don't-care while rx_valid = 0.

Reset
REQ-030 rst = 0 SHALL immediately force: FSM IDLE, counters 0, synchronizer 1s, FIFO empty, rx_valid 0, rx_full 0, overrun 0, frame_err 0, rx_data 8'h00.
REQ-031 rst asserted mid-frame SHALL discard the partial byte; after release, reception resumes at the next falling edge of rx.
REQ-032 rst release SHALL be the only synchronous-to-clk requirement; the FSM SHALL stay in IDLE on the first clock after release.

Verification (BUS_FREQ=100, BAUD=10_000_000 -> 10 clks/bit, FIFO_DEPTH_LOG2=2)
REQ-033 Send frame 0x55 with a valid stop bit -> rx_valid rises the clock after the stop sample, rx_data = 8'h55; rd_en pulse -> rx_valid = 0.
REQ-034 Low pulse on rx of 3 clocks -> no byte pushed, no flags set, FSM back in IDLE.
REQ-035 Send 0xA3 with the stop bit low, then hold rx low for 50 clocks -> frame_err = 1 once, FIFO empty; rx high, then 0x0F -> rx_data = 8'h0F.
REQ-036 Send 5 bytes 0x01..0x05 with no reads -> rx_full = 1 after the 4th byte, overrun = 1 after the 5th; reads return 01, 02, 03, 04.
REQ-037 FIFO full, rd_en asserted in the same cycle as the stop sample of 0x99 -> no overrun; reads return the remaining 3 bytes, then 0x99.
REQ-038 Assert rst during bit 4 of a frame -> all outputs at reset values; next full frame 0xC3 is received correctly.
